// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the key debounce family.
// State codes are fixed so that later debounce variants decode the same way.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b11,
        WAIT_LO = 2'b10
    } dbnc_state_e;

    localparam int unsigned DEF_STABLE_CYCLES = 1_000_000;
    localparam int unsigned DEF_CNT_W         = 20;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input.
// Both flops reset to 0, and there is no logic between them.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Debounces a raw key level into a clean registered level.
// Also produces one-cycle rise and fall pulses.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_out,
    output logic key_rise,
    output logic key_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic              key_raw;
    logic              ksync;
    dbnc_state_e       state;
    dbnc_state_e       state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              out_nxt;
    logic              rise_nxt;
    logic              fall_nxt;

    // Normalise polarity so that 1 always means pressed from here on.
    assign key_raw = ACTIVE_LOW ? ~key_in : key_in;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_raw),
        .q   (ksync)
    );

    // Next-state logic. A 0 on the final wait cycle still rejects the edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = key_out;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            IDLE_LO: begin
                if (ksync) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!ksync) begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_HI;
                    cnt_nxt   = '0;
                    out_nxt   = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (!ksync) begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LO: begin
                if (ksync) begin
                    state_nxt = IDLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
                    out_nxt   = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and stability counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE_LO;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Output registers, so downstream logic only sees flop outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_out  <= 1'b0;
            key_rise <= 1'b0;
            key_fall <= 1'b0;
        end else begin
            key_out  <= out_nxt;
            key_rise <= rise_nxt;
            key_fall <= fall_nxt;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboarded bench for key_debounce (STABLE_CYCLES=4, CNT_W=3).
// Includes a second instance built with ACTIVE_LOW=1.
module tb_key_debounce;

    localparam int unsigned STABLE = 4;
    localparam int unsigned CW     = 3;
    localparam int          LAT    = 6;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk       = 1'b0;
    logic rst       = 1'b0;
    logic key_in    = 1'b0;
    logic key_in_al = 1'b1;
    logic key_out, key_rise, key_fall;
    logic al_out, al_rise, al_fall;

    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    ev_t  exp_q[$];
    ev_t  mon_e;
    ev_t  mon_x;
    ev_t  push_e;

    key_debounce #(.STABLE_CYCLES(STABLE), .CNT_W(CW), .ACTIVE_LOW(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_out  (key_out),
        .key_rise (key_rise),
        .key_fall (key_fall)
    );

    key_debounce #(.STABLE_CYCLES(STABLE), .CNT_W(CW), .ACTIVE_LOW(1'b1)) dut_al (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in_al),
        .key_out  (al_out),
        .key_rise (al_rise),
        .key_fall (al_fall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every pulse seen must match the oldest expected event (kind 1 = rise, 0 = fall).
    always @(negedge clk) begin
        if (key_rise === 1'b1 || key_fall === 1'b1) begin
            mon_e.kind = (key_rise === 1'b1 && key_fall === 1'b1) ? 2 : (key_rise === 1'b1 ? 1 : 0);
            mon_e.cyc  = cyc;
            n_total    = n_total + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: got kind=%0d at cyc=%0d, required none", mon_e.kind, mon_e.cyc);
            end else begin
                mon_x = exp_q.pop_front();
                if (mon_e.kind !== mon_x.kind || mon_e.cyc !== mon_x.cyc)
                    $display("FAIL pulse: got kind=%0d cyc=%0d, required kind=%0d cyc=%0d",
                             mon_e.kind, mon_e.cyc, mon_x.kind, mon_x.cyc);
                else
                    n_pass = n_pass + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        logic [3:0] got;
        repeat (3) @(negedge clk);
        got = {key_out, key_rise, key_fall, al_out};
        n_total = n_total + 1;
        if (got !== 4'b0000) $display("FAIL reset_hold: got %b, required 0000", got);
        else n_pass = n_pass + 1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        got = {key_out, key_rise, key_fall, al_out};
        n_total = n_total + 1;
        if (got !== 4'b0000) $display("FAIL reset_idle: got %b, required 0000", got);
        else n_pass = n_pass + 1;
    endtask

    task automatic test_press();
        int   e1;
        logic exp_lvl;
        @(negedge clk);
        key_in = 1'b1;
        e1 = cyc + 1;
        push_e.kind = 1; push_e.cyc = e1 + LAT; exp_q.push_back(push_e);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp_lvl = (cyc >= e1 + LAT);
            n_total = n_total + 1;
            if (key_out !== exp_lvl)
                $display("FAIL press_level: cyc=%0d key_out=%b, required %b", cyc, key_out, exp_lvl);
            else
                n_pass = n_pass + 1;
        end
        #1;
        n_total = n_total + 1;
        if (exp_q.size() !== 0) $display("FAIL press_pending: %0d events outstanding, required 0", exp_q.size());
        else n_pass = n_pass + 1;
    endtask

    task automatic test_release();
        int   e1;
        logic exp_lvl;
        @(negedge clk);
        key_in = 1'b0;
        e1 = cyc + 1;
        push_e.kind = 0; push_e.cyc = e1 + LAT; exp_q.push_back(push_e);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_lvl = (cyc < e1 + LAT);
            n_total = n_total + 1;
            if (key_out !== exp_lvl)
                $display("FAIL release_level: cyc=%0d key_out=%b, required %b", cyc, key_out, exp_lvl);
            else
                n_pass = n_pass + 1;
        end
        #1;
        n_total = n_total + 1;
        if (exp_q.size() !== 0) $display("FAIL release_pending: %0d events outstanding, required 0", exp_q.size());
        else n_pass = n_pass + 1;
    endtask

    task automatic test_bounce();
        int   e1;
        logic exp_lvl;
        @(negedge clk);
        key_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) key_in = 1'b0;
            n_total = n_total + 1;
            if (key_out !== 1'b0) $display("FAIL bounce_level: cyc=%0d key_out=%b, required 0", cyc, key_out);
            else n_pass = n_pass + 1;
        end
        key_in = 1'b1;
        e1 = cyc + 1;
        push_e.kind = 1; push_e.cyc = e1 + LAT; exp_q.push_back(push_e);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_lvl = (cyc >= e1 + LAT);
            n_total = n_total + 1;
            if (key_out !== exp_lvl)
                $display("FAIL bounce_settle: cyc=%0d key_out=%b, required %b", cyc, key_out, exp_lvl);
            else
                n_pass = n_pass + 1;
        end
        #1;
        n_total = n_total + 1;
        if (exp_q.size() !== 0) $display("FAIL bounce_pending: %0d events outstanding, required 0", exp_q.size());
        else n_pass = n_pass + 1;
    endtask

    task automatic test_glitch();
        int width;
        for (int g = 0; g < 2; g++) begin
            width = (g == 0) ? 1 : 4;
            @(negedge clk);
            key_in = 1'b1;
            repeat (width) @(negedge clk);
            key_in = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                n_total = n_total + 1;
                if (key_out !== 1'b0)
                    $display("FAIL glitch_level: width=%0d cyc=%0d key_out=%b, required 0", width, cyc, key_out);
                else
                    n_pass = n_pass + 1;
            end
        end
    endtask

    task automatic test_reset_mid();
        int e1;
        logic [2:0] got;
        // Reset while pressed: key_out must drop without waiting for a clock.
        @(negedge clk);
        key_in = 1'b1;
        e1 = cyc + 1;
        push_e.kind = 1; push_e.cyc = e1 + LAT; exp_q.push_back(push_e);
        repeat (10) @(negedge clk);
        n_total = n_total + 1;
        if (key_out !== 1'b1) $display("FAIL pre_reset_level: key_out=%b, required 1", key_out);
        else n_pass = n_pass + 1;
        #2 rst = 1'b0;
        #1;
        got = {key_out, key_rise, key_fall};
        n_total = n_total + 1;
        if (got !== 3'b000) $display("FAIL reset_in_idle_hi: outputs=%b, required 000", got);
        else n_pass = n_pass + 1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        e1 = cyc + 1;
        push_e.kind = 1; push_e.cyc = e1 + LAT; exp_q.push_back(push_e);
        repeat (10) @(negedge clk);
        n_total = n_total + 1;
        if (key_out !== 1'b1) $display("FAIL held_after_reset: key_out=%b, required 1", key_out);
        else n_pass = n_pass + 1;
        test_release();
        // Reset two cycles into WAIT_HI; the in-flight rise is cancelled.
        @(negedge clk);
        key_in = 1'b1;
        e1 = cyc + 1;
        push_e.kind = 1; push_e.cyc = e1 + LAT; exp_q.push_back(push_e);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        void'(exp_q.pop_back());
        got = {key_out, key_rise, key_fall};
        n_total = n_total + 1;
        if (got !== 3'b000) $display("FAIL reset_mid_wait: outputs=%b, required 000", got);
        else n_pass = n_pass + 1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        e1 = cyc + 1;
        push_e.kind = 1; push_e.cyc = e1 + LAT; exp_q.push_back(push_e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_total = n_total + 1;
            if (key_out !== (cyc >= e1 + LAT))
                $display("FAIL reset_release_level: cyc=%0d key_out=%b", cyc, key_out);
            else
                n_pass = n_pass + 1;
        end
        #1;
        n_total = n_total + 1;
        if (exp_q.size() !== 0) $display("FAIL reset_pending: %0d events outstanding, required 0", exp_q.size());
        else n_pass = n_pass + 1;
        test_release();
    endtask

    task automatic test_active_low();
        int e1;
        logic [2:0] got;
        logic [2:0] want;
        @(negedge clk);
        key_in_al = 1'b0;
        e1 = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            got  = {al_out, al_rise, al_fall};
            want = {1'(cyc >= e1 + LAT), 1'(cyc == e1 + LAT), 1'b0};
            n_total = n_total + 1;
            if (got !== want) $display("FAIL al_press: cyc=%0d out/rise/fall=%b, required %b", cyc, got, want);
            else n_pass = n_pass + 1;
        end
        key_in_al = 1'b1;
        e1 = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            got  = {al_out, al_rise, al_fall};
            want = {1'(cyc < e1 + LAT), 1'b0, 1'(cyc == e1 + LAT)};
            n_total = n_total + 1;
            if (got !== want) $display("FAIL al_release: cyc=%0d out/rise/fall=%b, required %b", cyc, got, want);
            else n_pass = n_pass + 1;
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_release();
        test_glitch();
        test_reset_mid();
        test_active_low();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
